// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: shadows the EX/MEM/WB control state
// to generate forwarding selects, load-use stalls, branch flushes and event counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             reg_write_d,
  input  logic             result_src_d,
  input  logic             pc_src_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [4:0]       r_rs1_e;
  logic [4:0]       r_rs2_e;
  logic [4:0]       r_rd_e;
  logic             r_reg_write_e;
  logic             r_result_src_e;
  logic [4:0]       r_rd_m;
  logic             r_reg_write_m;
  logic [4:0]       r_rd_w;
  logic             r_reg_write_w;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_lw_stall;
  logic w_flush_e;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // A taken branch suppresses the load-use stall; reset forces every control output low.
  always_comb begin
    w_lw_stall = ~rst & r_result_src_e & r_reg_write_e & (r_rd_e != 5'd0) &
                 ((r_rd_e == rs1_d) | (r_rd_e == rs2_d)) & ~pc_src_e;
    w_flush_e  = w_lw_stall | (~rst & pc_src_e);
  end

  always_comb begin
    stall_f     = w_lw_stall;
    stall_d     = w_lw_stall;
    flush_d     = ~rst & pc_src_e;
    flush_e     = w_flush_e;
    forward_a_e = rst ? 2'b00 : fwd_sel(r_rs1_e, r_rd_m, r_reg_write_m, r_rd_w, r_reg_write_w);
    forward_b_e = rst ? 2'b00 : fwd_sel(r_rs2_e, r_rd_m, r_reg_write_m, r_rd_w, r_reg_write_w);
    stall_count = r_stall_cnt;
    flush_count = r_flush_cnt;
  end

  // E mirrors ID/EX, which takes a bubble (not a hold) while the front end stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1_e        <= 5'd0;
      r_rs2_e        <= 5'd0;
      r_rd_e         <= 5'd0;
      r_reg_write_e  <= 1'b0;
      r_result_src_e <= 1'b0;
      r_rd_m         <= 5'd0;
      r_reg_write_m  <= 1'b0;
      r_rd_w         <= 5'd0;
      r_reg_write_w  <= 1'b0;
    end else begin
      if (w_flush_e) begin
        r_rs1_e        <= 5'd0;
        r_rs2_e        <= 5'd0;
        r_rd_e         <= 5'd0;
        r_reg_write_e  <= 1'b0;
        r_result_src_e <= 1'b0;
      end else begin
        r_rs1_e        <= rs1_d;
        r_rs2_e        <= rs2_d;
        r_rd_e         <= rd_d;
        r_reg_write_e  <= reg_write_d;
        r_result_src_e <= result_src_d;
      end
      r_rd_m        <= r_rd_e;
      r_reg_write_m <= r_reg_write_e;
      r_rd_w        <= r_rd_m;
      r_reg_write_w <= r_reg_write_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lw_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (pc_src_e && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush, saturation, reset.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d, result_src_d, pc_src_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [15:0] stall_count, flush_count;
  logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_count, s_flush_count;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .pc_src_e(pc_src_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .pc_src_e(pc_src_e),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d), .flush_e(s_flush_e),
    .forward_a_e(s_fwd_a), .forward_b_e(s_fwd_b),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the D-stage fields and let the combinational outputs settle.
  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld);
    rs1_d = rs1; rs2_d = rs2; rd_d = rd; reg_write_d = rw; result_src_d = ld;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pc_src_e = 1'b1;
    set_d(5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    tick();
    chk("rst_flush_d", 16'(flush_d), 16'd0);
    chk("rst_flush_e", 16'(flush_e), 16'd0);
    chk("rst_stall_d", 16'(stall_d), 16'd0);
    chk("rst_fwd_a", 16'(forward_a_e), 16'd0);
    chk("rst_stall_cnt", stall_count, 16'd0);
    chk("rst_flush_cnt", flush_count, 16'd0);
    tick();
    rst = 1'b0;
    pc_src_e = 1'b0;
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();

    // ALU back-to-back forwarding
    set_d(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    set_d(5'd5, 5'd3, 5'd8, 1'b1, 1'b0);   // sub x8, x5, x3
    chk("alu_no_stall", 16'(stall_d), 16'd0);
    tick();
    chk("alu_fwd_a_mem", 16'(forward_a_e), 16'd2);
    chk("alu_fwd_b_none", 16'(forward_b_e), 16'd0);
    set_d(5'd4, 5'd5, 5'd9, 1'b1, 1'b0);   // or x9, x4, x5
    tick();
    chk("alu_fwd_b_wb", 16'(forward_b_e), 16'd1);
    chk("alu_fwd_a_none", 16'(forward_a_e), 16'd0);

    // Load-use
    set_d(5'd2, 5'd0, 5'd6, 1'b1, 1'b1);   // lw x6
    chk("ld_no_stall_yet", 16'(stall_d), 16'd0);
    tick();
    set_d(5'd1, 5'd6, 5'd10, 1'b1, 1'b0);  // add x10, x1, x6
    chk("lu_stall_f", 16'(stall_f), 16'd1);
    chk("lu_stall_d", 16'(stall_d), 16'd1);
    chk("lu_flush_e", 16'(flush_e), 16'd1);
    chk("lu_flush_d", 16'(flush_d), 16'd0);
    chk("lu_cnt_before", stall_count, 16'd0);
    tick();
    chk("lu_cnt_after", stall_count, 16'd1);
    chk("lu_stall_drops", 16'(stall_d), 16'd0);
    chk("lu_flush_e_drops", 16'(flush_e), 16'd0);
    tick();
    chk("lu_fwd_b_wb", 16'(forward_b_e), 16'd1);
    chk("lu_cnt_hold", stall_count, 16'd1);

    // Double match: MEM wins; x0 never forwards
    set_d(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    set_d(5'd7, 5'd0, 5'd11, 1'b1, 1'b0);
    tick();
    chk("dbl_fwd_a_mem", 16'(forward_a_e), 16'd2);
    set_d(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
    tick();
    chk("x0_fwd_a", 16'(forward_a_e), 16'd0);
    chk("x0_fwd_b", 16'(forward_b_e), 16'd0);

    // Load to x0 never stalls
    set_d(5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    set_d(5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
    chk("x0_no_stall", 16'(stall_d), 16'd0);
    tick();

    // Branch flush: flushed load must not reach E
    pc_src_e = 1'b1;
    set_d(5'd3, 5'd4, 5'd14, 1'b1, 1'b1);
    chk("br_flush_d", 16'(flush_d), 16'd1);
    chk("br_flush_e", 16'(flush_e), 16'd1);
    chk("br_stall_f", 16'(stall_f), 16'd0);
    chk("br_cnt_before", flush_count, 16'd0);
    tick();
    pc_src_e = 1'b0;
    set_d(5'd14, 5'd0, 5'd15, 1'b1, 1'b0);
    chk("br_cnt_after", flush_count, 16'd1);
    chk("br_e_bubble", 16'(stall_d), 16'd0);
    chk("br_flush_d_drops", 16'(flush_d), 16'd0);
    tick();

    // Forced overlap of branch and load-use: flush wins
    set_d(5'd0, 5'd0, 5'd15, 1'b1, 1'b1);
    tick();
    pc_src_e = 1'b1;
    set_d(5'd15, 5'd0, 5'd16, 1'b1, 1'b0);
    chk("ovl_stall_f", 16'(stall_f), 16'd0);
    chk("ovl_stall_d", 16'(stall_d), 16'd0);
    chk("ovl_flush_d", 16'(flush_d), 16'd1);
    chk("ovl_flush_e", 16'(flush_e), 16'd1);
    tick();
    pc_src_e = 1'b0;
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("ovl_flush_cnt", flush_count, 16'd2);
    chk("ovl_stall_cnt", stall_count, 16'd1);
    tick();

    // Saturation: five more load-use stalls
    for (int i = 0; i < 5; i++) begin
      set_d(5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
      tick();
      set_d(5'd6, 5'd0, 5'd10, 1'b1, 1'b0);
      chk("sat_stall", 16'(s_stall_d), 16'd1);
      tick();
    end
    chk("sat_stall_cnt", 16'(s_stall_count), 16'd3);
    chk("wide_stall_cnt", stall_count, 16'd6);
    pc_src_e = 1'b1;
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    pc_src_e = 1'b0;
    #1;
    chk("sat_flush_cnt", 16'(s_flush_count), 16'd3);
    chk("wide_flush_cnt", flush_count, 16'd4);

    // Reset asserted mid-stall
    set_d(5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
    tick();
    set_d(5'd6, 5'd0, 5'd10, 1'b1, 1'b0);
    chk("rms_stall_pre", 16'(stall_d), 16'd1);
    rst = 1'b1;
    #1;
    chk("rms_stall_f", 16'(stall_f), 16'd0);
    chk("rms_stall_d", 16'(stall_d), 16'd0);
    chk("rms_flush_e", 16'(flush_e), 16'd0);
    chk("rms_stall_cnt", stall_count, 16'd0);
    chk("rms_flush_cnt", flush_count, 16'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_no_stall", 16'(stall_d), 16'd0);
    tick();
    chk("rel_fwd_a", 16'(forward_a_e), 16'd0);
    chk("rel_fwd_b", 16'(forward_b_e), 16'd0);
    chk("rel_stall_cnt", stall_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
